// File: rtl/sn74xx251.sv
// 8-to-1 selector with complementary tri-state outputs and a synchronous bus-release reset.
// Optional SN74XX251_REG_OUT_EN adds a registered data/enable stage ahead of the drivers.
module sn74xx251 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [2:0] sel,
  input  logic       oe,
  output logic       out,
  output logic       _out
);

  logic arm_q;
  logic y;
  logic en;
  logic d;

  // The bus stays released until the first edge that samples rst low.
  always_ff @(posedge clk) begin
    if (rst) arm_q <= 1'b0;
    else     arm_q <= 1'b1;
  end

  always_comb begin
    y = a[sel];
  end

`ifdef SN74XX251_REG_OUT_EN
  logic d_q;
  logic en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= 1'b0;
      en_q <= 1'b0;
    end else begin
      d_q  <= y;
      en_q <= ~oe;
    end
  end

  always_comb begin
    en = en_q & arm_q;
    d  = d_q;
  end
`else
  always_comb begin
    en = arm_q & ~oe;
    d  = y;
  end
`endif

  // Both drivers share one enable, so the pair is always complementary or both released.
  assign out  = en ? d  : 1'bz;
  assign _out = en ? ~d : 1'bz;

endmodule

// File: tb/tb_sn74xx251.sv
// Directed-vector bench for sn74xx251; high-Z is detected by overdriving the bus from the bench.
module tb_sn74xx251;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [2:0] sel;
  logic       oe;
  wire        out_w;
  wire        nout_w;
  logic       prb_en  = 1'b0;
  logic       prb_val = 1'b0;
  int         nvec    = 0;
  int         nmis    = 0;

  // Bench-side keeper: only wins the net when the DUT has released it.
  assign out_w  = prb_en ? prb_val : 1'bz;
  assign nout_w = prb_en ? prb_val : 1'bz;

  sn74xx251 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .sel  (sel),
    .oe   (oe),
    .out  (out_w),
    ._out (nout_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
`ifdef SN74XX251_REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  // Driven check: probe off, expect {out,_out} = {b,~b}.
  task automatic chk_drv(input string tag, input logic b);
    prb_en = 1'b0;
    #1;
    chk(tag, {2'b00, out_w, nout_w}, {2'b00, b, ~b});
  endtask

  // High-Z check: both outputs must follow the probe driving 1 and then 0.
  task automatic chk_z(input string tag);
    logic o1, n1, o0, n0;
    prb_en = 1'b1; prb_val = 1'b1; #1;
    o1 = out_w; n1 = nout_w;
    prb_val = 1'b0; #1;
    o0 = out_w; n0 = nout_w;
    prb_en = 1'b0; #1;
    chk(tag, {o1, n1, o0, n0}, 4'b1100);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'hA5;
    rst = 1'b1; oe = 1'b0; a = 8'hA5; sel = 3'd0;
    tick(); tick();
    chk_z("reset_z");

    rst = 1'b0;
    tick();
    chk_drv("reset_release", 1'b1);

    for (int i = 0; i < 8; i++) begin
      sel = i[2:0];
      settle();
      chk_drv($sformatf("sweep_sel%0d", i), pat[i]);
    end

    oe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = i[2:0];
      a   = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      settle();
      chk_z($sformatf("strobe_sel%0d", i));
    end

    oe = 1'b0; sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 8'h08 : 8'h00;
      settle();
      chk_drv($sformatf("follow_%0d", i), (i % 2 == 0));
    end

    a = 8'hFF; sel = 3'd0; oe = 1'b0;
    settle();
    chk_drv("midop_pre", 1'b1);
    rst = 1'b1;
    #1;
    chk_drv("midop_before_edge", 1'b1);
    tick();
    chk_z("midop_released");
    rst = 1'b0;
    #1;
    chk_z("midop_wait_edge");
    tick();
    chk_drv("midop_rearmed", 1'b1);

`ifdef SN74XX251_REG_OUT_EN
    a = 8'hA5; sel = 3'd0;
    tick();
    chk_drv("reg_sel0", 1'b1);
    sel = 3'd1;
    #1;
    chk_drv("reg_hold", 1'b1);
    tick();
    chk_drv("reg_sel1", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
